// File: rtl/sensor_scan_sampler_pkg.sv
// Shared definitions for the sensor scan sampler and the relay supervisors that consume its samples.
// Holds the scan FSM state encoding, the clog2 helper and the sample record widths.
package sensor_scan_sampler_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int SEN_W    = 10;
    localparam int SCAN_CH  = 4;
    localparam int CH_IDX_W = clog2(SCAN_CH);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_EMIT   = 3'd4;

endpackage

// File: rtl/sensor_scan_sampler_adc_handshake.sv
// ADC start/done handshake: registered start strobe, WAIT-cycle counter and the
// done-versus-timeout decision reported back to the scan FSM.
module adc_handshake
    import sensor_scan_sampler_pkg::*;
#(
    parameter int W_SEN   = SEN_W,
    parameter int TIMEOUT = 8
) (
    input  logic             clk_16ms,
    input  logic             rst,
    input  logic [2:0]       fsm_state,
    input  logic [2:0]       fsm_state_next,
    input  logic             adc_done,
    input  logic [W_SEN-1:0] adc_data,
    output logic             adc_start,
    output logic             conv_ok,
    output logic [W_SEN-1:0] conv_data,
    output logic             conv_timeout
);

    localparam int TO_W = clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] LAST_WAIT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            adc_start_q, adc_start_d;
    logic            in_wait;

    // A done pulse on the final WAIT cycle still counts as a good conversion.
    always_comb begin
        in_wait      = (fsm_state == ST_WAIT);
        wait_cnt_d   = in_wait ? wait_cnt_q + 1'b1 : '0;
        adc_start_d  = (fsm_state_next == ST_START);
        conv_ok      = in_wait && adc_done;
        conv_timeout = in_wait && !adc_done && (wait_cnt_q == LAST_WAIT);
        conv_data    = adc_data;
    end

    always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
            wait_cnt_q  <= '0;
            adc_start_q <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            adc_start_q <= adc_start_d;
        end
    end

    assign adc_start = adc_start_q;

endmodule

// File: rtl/sensor_scan_sampler.sv
// Scans N_CH sensor channels through an analog mux and a start/done ADC, averaging
// 2**AVG_LOG2 conversions per channel and strobing each result with a one-hot enable.
module sensor_scan_sampler
    import sensor_scan_sampler_pkg::*;
#(
    parameter int N_CH     = SCAN_CH,
    parameter int W_SEN    = SEN_W,
    parameter int AVG_LOG2 = 2,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 8
) (
    input  logic                     clk_16ms,
    input  logic                     rst,
    input  logic                     run,
    input  logic                     clr_err,
    input  logic                     adc_done,
    input  logic [W_SEN-1:0]         adc_data,
    output logic                     adc_start,
    output logic [clog2(N_CH)-1:0]   mux_sel,
    output logic [W_SEN-1:0]         sample_out,
    output logic [clog2(N_CH)-1:0]   sample_ch,
    output logic                     sample_valid,
    output logic [N_CH-1:0]          enable_out,
    output logic                     scan_done,
    output logic [N_CH-1:0]          adc_timeout_err
);

    localparam int CH_W   = clog2(N_CH);
    localparam int ACC_W  = W_SEN + AVG_LOG2;
    localparam int SET_W  = clog2(SETTLE + 1);
    localparam int SCNT_W = AVG_LOG2 + 1;
    localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(N_CH - 1);
    localparam logic [SET_W-1:0]  LAST_SETTLE = SET_W'(SETTLE - 1);
    localparam logic [SCNT_W-1:0] LAST_CONV   = SCNT_W'((1 << AVG_LOG2) - 1);

    logic [2:0]        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_nxt;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
    logic [W_SEN-1:0]  sample_out_q, sample_out_d;
    logic [CH_W-1:0]   sample_ch_q, sample_ch_d;
    logic              sample_valid_q, sample_valid_d;
    logic [N_CH-1:0]   enable_out_q, enable_out_d;
    logic              scan_done_q, scan_done_d;

    logic              conv_ok, conv_timeout;
    logic [W_SEN-1:0]  conv_data;

    function automatic logic [W_SEN-1:0] avg_trunc(input logic [ACC_W-1:0] acc);
        return W_SEN'(acc >> AVG_LOG2);
    endfunction

    adc_handshake #(
        .W_SEN   (W_SEN),
        .TIMEOUT (TIMEOUT)
    ) u_adc_handshake (
        .clk_16ms       (clk_16ms),
        .rst            (rst),
        .fsm_state      (state_q),
        .fsm_state_next (state_d),
        .adc_done       (adc_done),
        .adc_data       (adc_data),
        .adc_start      (adc_start),
        .conv_ok        (conv_ok),
        .conv_data      (conv_data),
        .conv_timeout   (conv_timeout)
    );

    always_comb begin
        ch_nxt   = (ch_q == LAST_CH) ? '0 : ch_q + 1'b1;
        state_d  = state_q;
        ch_d     = ch_q;
        settle_d = settle_q;
        scnt_d   = scnt_q;
        acc_d    = acc_q;
        err_d    = clr_err ? '0 : err_q;

        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (settle_q == LAST_SETTLE) state_d = ST_START;
                else                         settle_d = settle_q + 1'b1;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (conv_ok) begin
                    acc_d   = acc_q + ACC_W'(conv_data);
                    scnt_d  = scnt_q + 1'b1;
                    state_d = (scnt_q == LAST_CONV) ? ST_EMIT : ST_START;
                end else if (conv_timeout) begin
                    // Abandon the channel: flag it, drop the partial sum, move on.
                    err_d[ch_q] = 1'b1;
                    ch_d        = ch_nxt;
                    state_d     = run ? ST_SELECT : ST_IDLE;
                end
            end
            ST_EMIT: begin
                ch_d    = ch_nxt;
                state_d = run ? ST_SELECT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_SELECT && state_q != ST_SELECT) begin
            acc_d    = '0;
            scnt_d   = '0;
            settle_d = '0;
        end

        // Outputs are registered, so they are computed from the state being entered.
        sample_valid_d = (state_d == ST_EMIT);
        enable_out_d   = sample_valid_d ? (N_CH'(1) << ch_q) : '0;
        scan_done_d    = sample_valid_d && (ch_q == LAST_CH);
        sample_out_d   = sample_valid_d ? avg_trunc(acc_d) : sample_out_q;
        sample_ch_d    = sample_valid_d ? ch_q : sample_ch_q;
        mux_sel_d      = (state_d == ST_SELECT) ? ch_d : mux_sel_q;
    end

    always_ff @(posedge clk_16ms or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            ch_q           <= '0;
            settle_q       <= '0;
            scnt_q         <= '0;
            err_q          <= '0;
            mux_sel_q      <= '0;
            sample_out_q   <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            enable_out_q   <= '0;
            scan_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_q           <= ch_d;
            settle_q       <= settle_d;
            scnt_q         <= scnt_d;
            err_q          <= err_d;
            mux_sel_q      <= mux_sel_d;
            sample_out_q   <= sample_out_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            enable_out_q   <= enable_out_d;
            scan_done_q    <= scan_done_d;
        end
    end

    // The accumulator is cleared on every SELECT entry, so it needs no reset.
    always_ff @(posedge clk_16ms) begin
        acc_q <= acc_d;
    end

    assign mux_sel         = mux_sel_q;
    assign sample_out      = sample_out_q;
    assign sample_ch       = sample_ch_q;
    assign sample_valid    = sample_valid_q;
    assign enable_out      = enable_out_q;
    assign scan_done       = scan_done_q;
    assign adc_timeout_err = err_q;

endmodule

// File: tb/tb_sensor_scan_sampler.sv
// Bench for sensor_scan_sampler: an ADC responder driven from a conversion plan, and a
// timeline model built from the channel timing rules that every output is compared against.
module tb_sensor_scan_sampler;
    import sensor_scan_sampler_pkg::*;

    localparam int N_CH = 4, W_SEN = 10, AVG_LOG2 = 2, SETTLE = 2, TIMEOUT = 8;
    localparam int N_AVG = 1 << AVG_LOG2;
    localparam int MAXC = 700, MAXP = 256;

    logic clk_16ms = 1'b0, rst = 1'b1, run = 1'b0, clr_err = 1'b0, adc_done = 1'b0;
    logic [W_SEN-1:0] adc_data = '0;
    logic adc_start, sample_valid, scan_done;
    logic [CH_IDX_W-1:0] mux_sel, sample_ch;
    logic [W_SEN-1:0] sample_out;
    logic [N_CH-1:0] enable_out, adc_timeout_err;

    sensor_scan_sampler #(
        .N_CH(N_CH), .W_SEN(W_SEN), .AVG_LOG2(AVG_LOG2), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_16ms(clk_16ms), .rst(rst), .run(run), .clr_err(clr_err),
        .adc_done(adc_done), .adc_data(adc_data), .adc_start(adc_start),
        .mux_sel(mux_sel), .sample_out(sample_out), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .enable_out(enable_out), .scan_done(scan_done),
        .adc_timeout_err(adc_timeout_err)
    );

    always #5 clk_16ms = ~clk_16ms;

    int nerr, nchk;

    // Stimulus plan: per conversion a delay d (0 = done never arrives) and the data.
    int plan_d[MAXP], plan_data[MAXP], plan_len;
    bit run_at[MAXC+2], clr_at[MAXC+2];

    // Expected timeline, index = cycle number after reset release.
    bit exp_valid[MAXC], exp_start[MAXC];
    int exp_ch[MAXC], exp_data[MAXC], exp_mux[MAXC], to_ch[MAXC];
    logic [N_CH-1:0] exp_err[MAXC];

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, k, got, want);
        end
    endtask

    function automatic int pd(input int i);
        return (i < plan_len) ? plan_d[i] : 1;
    endfunction

    function automatic int pdat(input int i);
        return (i < plan_len) ? plan_data[i] : 0;
    endfunction

    task automatic clear_setup();
        plan_len = 0;
        for (int i = 0; i < MAXC + 2; i++) begin
            run_at[i] = 1'b1;
            clr_at[i] = 1'b0;
        end
    endtask

    task automatic add_conv(input int d, input int data);
        plan_d[plan_len] = d;
        plan_data[plan_len] = data;
        plan_len++;
    endtask

    // Cycle of the next SELECT entry after a channel ends in cycle e (e = -1: from reset).
    function automatic int next_sel(input int e);
        if (e >= 0 && run_at[e]) return e + 1;
        for (int k = e + 1; k < MAXC; k++)
            if (run_at[k]) return k + 1;
        return MAXC + 10;
    endfunction

    function automatic int count_valid(input int a, input int b);
        int n;
        n = 0;
        for (int k = a; k <= b; k++) n += int'(exp_valid[k]);
        return n;
    endfunction

    task automatic build_model(input int ncyc);
        int t, s, e, ch, qi, n, acc, d;
        bit to;
        logic [N_CH-1:0] err;
        for (int c = 0; c < MAXC; c++) begin
            exp_valid[c] = 0; exp_start[c] = 0; exp_ch[c] = 0; exp_data[c] = 0;
            exp_mux[c] = 0; to_ch[c] = -1; exp_err[c] = '0;
        end
        ch = 0; qi = 0; e = 0;
        t = next_sel(-1);
        while (t < ncyc) begin
            s = t + SETTLE; acc = 0; n = 0; to = 0;
            while (n < N_AVG && !to) begin
                d = pd(qi);
                if (s < MAXC) begin exp_start[s] = 1; exp_mux[s] = ch; end
                if (d == 0) begin
                    to = 1;
                    e = s + TIMEOUT;
                end else begin
                    acc += pdat(qi);
                    n++;
                    s += 1 + d;
                end
                qi++;
            end
            if (to) begin
                if (e < MAXC) to_ch[e] = ch;
            end else begin
                e = s;
                if (e < MAXC) begin exp_valid[e] = 1; exp_ch[e] = ch; exp_data[e] = acc >> AVG_LOG2; end
            end
            ch = (ch + 1) % N_CH;
            t = next_sel(e);
        end
        err = '0;
        for (int c = 0; c < ncyc; c++) begin
            exp_err[c] = err;
            if (clr_at[c]) err = '0;
            if (to_ch[c] >= 0) err[to_ch[c]] = 1'b1;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".adc_start"}, -1, 32'(adc_start), 0);
        chk({nm, ".mux_sel"}, -1, 32'(mux_sel), 0);
        chk({nm, ".sample_out"}, -1, 32'(sample_out), 0);
        chk({nm, ".sample_ch"}, -1, 32'(sample_ch), 0);
        chk({nm, ".sample_valid"}, -1, 32'(sample_valid), 0);
        chk({nm, ".enable_out"}, -1, 32'(enable_out), 0);
        chk({nm, ".scan_done"}, -1, 32'(scan_done), 0);
        chk({nm, ".adc_timeout_err"}, -1, 32'(adc_timeout_err), 0);
    endtask

    task automatic compare_cycle(input int k);
        logic [N_CH-1:0] en_want;
        en_want = exp_valid[k] ? (N_CH'(1) << exp_ch[k]) : '0;
        chk("sample_valid", k, 32'(sample_valid), 32'(exp_valid[k]));
        chk("enable_out", k, 32'(enable_out), 32'(en_want));
        chk("scan_done", k, 32'(scan_done), 32'(exp_valid[k] && exp_ch[k] == N_CH - 1));
        if (exp_valid[k]) begin
            chk("sample_ch", k, 32'(sample_ch), 32'(exp_ch[k]));
            chk("sample_out", k, 32'(sample_out), 32'(exp_data[k]));
        end
        chk("adc_timeout_err", k, 32'(adc_timeout_err), 32'(exp_err[k]));
        chk("adc_start", k, 32'(adc_start), 32'(exp_start[k]));
        if (exp_start[k]) chk("mux_sel", k, 32'(mux_sel), 32'(exp_mux[k]));
    endtask

    // Inputs for cycle k are driven at its falling edge, right after its outputs are compared.
    task automatic run_phase(input int ncyc);
        int rsp_cnt, rsp_data, plan_rd, d;
        build_model(ncyc);
        rst = 1'b1; run = 1'b0; clr_err = 1'b0; adc_done = 1'b0; adc_data = '0;
        rsp_cnt = 0; rsp_data = 0; plan_rd = 0;
        repeat (2) @(negedge clk_16ms);
        chk_zero("reset");
        run = run_at[0]; clr_err = clr_at[0];
        rst = 1'b0;
        for (int k = 1; k < ncyc; k++) begin
            @(negedge clk_16ms);
            compare_cycle(k);
            adc_done = 1'b0;
            adc_data = W_SEN'($urandom);
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin adc_done = 1'b1; adc_data = W_SEN'(rsp_data); end
            end
            if (adc_start) begin
                d = pd(plan_rd);
                rsp_data = pdat(plan_rd);
                plan_rd++;
                rsp_cnt = d;
            end
            run = run_at[k];
            clr_err = clr_at[k];
        end
    endtask

    task automatic random_setup();
        int k, len;
        bit v;
        clear_setup();
        for (int i = 0; i < N_AVG; i++) add_conv($urandom_range(1, 2), 1023);
        for (int i = 0; i < 200; i++)
            add_conv(($urandom_range(0, 15) == 0) ? 0 :
                     ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2) : $urandom_range(3, TIMEOUT),
                     $urandom_range(0, 1023));
        k = 0;
        while (k < MAXC + 2) begin
            v = ($urandom_range(0, 3) != 0);
            len = $urandom_range(5, 60);
            for (int j = 0; j < len && k < MAXC + 2; j++) begin run_at[k] = v; k++; end
        end
        for (int i = 0; i < MAXC + 2; i++) clr_at[i] = ($urandom_range(0, 40) == 0);
    endtask

    initial begin
        nerr = 0; nchk = 0;

        // Four channels, constant per-channel values, d=1.
        clear_setup();
        for (int c = 0; c < N_CH; c++)
            for (int i = 0; i < N_AVG; i++) add_conv(1, 100 * (c + 1));
        run_phase(60);
        chk("pin.start3", -1, 32'(exp_start[3]), 1);
        chk("pin.valid11", -1, 32'(exp_valid[11]), 1);
        chk("pin.data11", -1, 32'(exp_data[11]), 100);
        chk("pin.gap12_21", -1, 32'(count_valid(12, 21)), 0);
        chk("pin.ch22", -1, 32'(exp_ch[22]), 1);
        chk("pin.data33", -1, 32'(exp_data[33]), 300);
        chk("pin.ch44", -1, 32'(exp_ch[44]), 3);
        chk("pin.data44", -1, 32'(exp_data[44]), 400);

        // Truncating average, ch2 timeout, clr_err, done on the last allowed WAIT cycle.
        clear_setup();
        add_conv(1, 1); add_conv(1, 2); add_conv(1, 2); add_conv(1, 2);
        for (int i = 0; i < N_AVG; i++) add_conv(1, $urandom_range(0, 1023));
        add_conv(0, 0);
        for (int i = 0; i < N_AVG; i++) add_conv(1, $urandom_range(0, 1023));
        add_conv(TIMEOUT, 40); add_conv(1, 40); add_conv(1, 40); add_conv(1, 40);
        clr_at[50] = 1'b1;
        run_phase(80);
        chk("pin.avg7", -1, 32'(exp_data[11]), 1);
        chk("pin.err33", -1, 32'(exp_err[33]), 0);
        chk("pin.err34", -1, 32'(exp_err[34]), 4'b0100);
        chk("pin.noemit_ch2", -1, 32'(count_valid(23, 43)), 0);
        chk("pin.ch3_after_to", -1, 32'(exp_valid[44] && exp_ch[44] == 3), 1);
        chk("pin.err_cleared", -1, 32'(exp_err[51]), 0);
        chk("pin.late_done", -1, 32'(exp_valid[62] && exp_data[62] == 40), 1);
        chk("pin.late_noerr", -1, 32'(exp_err[63]), 0);

        // run dropped during ch1 WAIT, resumed later.
        clear_setup();
        for (int i = 0; i < 40; i++) add_conv(1, $urandom_range(0, 1023));
        for (int i = 15; i < 40; i++) run_at[i] = 1'b0;
        run_phase(70);
        chk("pin.ch1_emits", -1, 32'(exp_valid[22] && exp_ch[22] == 1), 1);
        chk("pin.idle_gap", -1, 32'(count_valid(23, 50)), 0);
        chk("pin.resume_ch2", -1, 32'(exp_valid[51] && exp_ch[51] == 2), 1);

        // Reset in the middle of ch3 WAIT, then a fresh scan from ch0.
        clear_setup();
        for (int i = 0; i < 3 * N_AVG; i++) add_conv(1, $urandom_range(1, 1023));
        add_conv(0, 0);
        run_phase(40);
        #2 rst = 1'b1;
        #1 chk_zero("rst_mid_wait");
        clear_setup();
        for (int i = 0; i < N_AVG; i++) add_conv(1, 500 + i);
        run_phase(50);
        chk("pin.restart_ch0", -1, 32'(exp_valid[11] && exp_ch[11] == 0 && exp_data[11] == 501), 1);

        // Randomised delays, timeouts, run gaps and clears.
        random_setup();
        run_phase(600);
        random_setup();
        run_phase(600);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
